// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: turns PS/2 set-2 scan bytes into calculator tokens
// (digit / operator / enter / clear). It handles break and extended prefixes,
// suppresses typematic repeats, abandons stalled prefixes and queues the
// tokens in a small FIFO.
module calc_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       tok_valid,
    input  logic       tok_ready,
    output logic [1:0] tok_type,
    output logic [3:0] tok_val,
    output logic       err_pulse,
    output logic       overflow,
    output logic       timeout_pulse
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] TT_DIGIT = 2'd0;
    localparam logic [1:0] TT_OP    = 2'd1;
    localparam logic [1:0] TT_ENTER = 2'd2;
    localparam logic [1:0] TT_CLEAR = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    // Make-code map: {recognised, type, value}
    function automatic logic [6:0] decode_make(input logic [7:0] c);
        case (c)
            8'h45:   decode_make = {1'b1, TT_DIGIT, 4'd0};
            8'h16:   decode_make = {1'b1, TT_DIGIT, 4'd1};
            8'h1E:   decode_make = {1'b1, TT_DIGIT, 4'd2};
            8'h26:   decode_make = {1'b1, TT_DIGIT, 4'd3};
            8'h25:   decode_make = {1'b1, TT_DIGIT, 4'd4};
            8'h2E:   decode_make = {1'b1, TT_DIGIT, 4'd5};
            8'h36:   decode_make = {1'b1, TT_DIGIT, 4'd6};
            8'h3D:   decode_make = {1'b1, TT_DIGIT, 4'd7};
            8'h3E:   decode_make = {1'b1, TT_DIGIT, 4'd8};
            8'h46:   decode_make = {1'b1, TT_DIGIT, 4'd9};
            8'h55:   decode_make = {1'b1, TT_OP,    4'd0};
            8'h4E:   decode_make = {1'b1, TT_OP,    4'd1};
            8'h5A:   decode_make = {1'b1, TT_ENTER, 4'd0};
            8'h76:   decode_make = {1'b1, TT_CLEAR, 4'd0};
            default: decode_make = 7'd0;
        endcase
    endfunction

    // Reset: asserts asynchronously, releases after two clock edges
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    // Reset synchronizer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    state_t              state_q, state_d;
    logic [7:0]          held_q, held_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                tpls_q, tpls_d;
    logic                push;
    logic [5:0]          push_tok;
    logic [6:0]          mk;

    logic [FIFO_DEPTH-1:0][5:0] mem_q, mem_d;
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                pop, full, do_push;

    // Decoder next state: prefix tracking, typematic filter, prefix timeout
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        tmo_d    = tmo_q;
        err_d    = 1'b0;
        tpls_d   = 1'b0;
        push     = 1'b0;
        push_tok = '0;
        mk       = decode_make(scan_code);
        if (scan_ready) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (scan_code == 8'hF0)      state_d = S_BRK;
                    else if (scan_code == 8'hE0) state_d = S_EXT;
                    else if (!mk[6])             err_d   = 1'b1;
                    else if (scan_code != held_q) begin
                        push     = 1'b1;
                        push_tok = mk[5:0];
                        held_d   = scan_code;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (scan_code == held_q) held_d = 8'h00;
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) state_d = S_EXT_BRK;
                    else begin
                        state_d = S_IDLE;
                        if (scan_code == 8'h5A) begin
                            push     = 1'b1;
                            push_tok = {TT_ENTER, 4'd0};
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
                tpls_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign tok_valid = (cnt_q != '0);
    assign full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign pop       = tok_valid & tok_ready;
    assign tok_type  = tok_valid ? mem_q[rptr_q][5:4] : 2'd0;
    assign tok_val   = tok_valid ? mem_q[rptr_q][3:0] : 4'd0;

    // Token FIFO next state; a full FIFO still accepts a push when popping
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        do_push = push & (~full | pop);
        if (push & full & ~pop) ovf_d = 1'b1;
        if (do_push) begin
            mem_d[wptr_q] = push_tok;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign err_pulse     = err_q;
    assign timeout_pulse = tpls_q;
    assign overflow      = ovf_q;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            held_q  <= 8'h00;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            tpls_q  <= 1'b0;
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            tpls_q  <= tpls_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed key sequences plus random byte
// streams, each cycle compared against a prefix-queue reference model.
module tb_calc_key_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_type;
    logic [3:0] tok_val;
    logic       err_pulse;
    logic       overflow;
    logic       timeout_pulse;

    calc_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_ready(scan_ready),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type),
        .tok_val(tok_val), .err_pulse(err_pulse), .overflow(overflow),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: tokens encoded as type*16+val
    logic [7:0] dig [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pend[$];
    int         m_q[$];
    int         got[$];
    logic [7:0] m_held;
    int         m_silent;
    bit         m_ovf, m_err, m_tmo;

    function automatic int lookup(input logic [7:0] c);
        for (int i = 0; i < 10; i++) if (c == dig[i]) return i;
        if (c == 8'h55) return 16;
        if (c == 8'h4E) return 17;
        if (c == 8'h5A) return 32;
        if (c == 8'h76) return 48;
        return -1;
    endfunction

    task automatic model_reset();
        pend.delete(); m_q.delete();
        m_held = 8'h00; m_silent = 0;
        m_ovf = 0; m_err = 0; m_tmo = 0;
    endtask

    task automatic model_step(input logic [7:0] c, input logic rdy, input logic trdy);
        bit push = 0;
        int tk = 0;
        bit pop;
        m_err = 0; m_tmo = 0;
        if (rdy) begin
            m_silent = 0;
            if (pend.size() == 0) begin
                if (c == 8'hF0 || c == 8'hE0) pend.push_back(c);
                else begin
                    tk = lookup(c);
                    if (tk < 0) m_err = 1;
                    else if (c != m_held) begin push = 1; m_held = c; end
                end
            end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
                if (c == m_held) m_held = 8'h00;
                pend.delete();
            end else if (pend.size() == 1 && pend[0] == 8'hE0 && c == 8'hF0) begin
                pend.push_back(c);
            end else begin
                if (pend.size() == 1 && c == 8'h5A) begin push = 1; tk = 32; end
                pend.delete();
            end
        end else if (pend.size() > 0) begin
            m_silent++;
            if (m_silent == TMO) begin pend.delete(); m_silent = 0; m_tmo = 1; end
        end
        pop = (m_q.size() > 0) && trdy;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back(tk);
        end
    endtask

    // One clock: called at a negedge, checks outputs, steps model at posedge
    task automatic cyc(input logic [7:0] c, input logic rdy, input logic trdy);
        scan_code = c; scan_ready = rdy; tok_ready = trdy;
        chk("tok_valid", int'(tok_valid), int'(m_q.size() > 0));
        chk("tok_type", int'(tok_type), (m_q.size() > 0) ? m_q[0] / 16 : 0);
        chk("tok_val", int'(tok_val), (m_q.size() > 0) ? m_q[0] % 16 : 0);
        chk("err_pulse", int'(err_pulse), int'(m_err));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("timeout_pulse", int'(timeout_pulse), int'(m_tmo));
        if (tok_valid && trdy) got.push_back(int'({tok_type, tok_val}));
        @(posedge clk);
        model_step(c, rdy, trdy);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic trdy);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, trdy);
    endtask

    task automatic send(input logic [7:0] c, input logic trdy);
        cyc(c, 1'b1, trdy);
    endtask

    task automatic do_reset();
        reset = 1'b0; scan_ready = 1'b0; tok_ready = 1'b0;
        #1;
        model_reset();
        chk("rst_tok_valid", int'(tok_valid), 0);
        chk("rst_tok_type", int'(tok_type), 0);
        chk("rst_tok_val", int'(tok_val), 0);
        chk("rst_err", int'(err_pulse), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_tmo", int'(timeout_pulse), 0);
        @(negedge clk);
        idle(2, 1'b0);
        reset = 1'b1;
        idle(3, 1'b0);
        got.delete();
    endtask

    task automatic chk_got(input string tag, input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(tag, got[i], exp[i]);
    endtask

    logic [7:0] pool [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h55, 8'h4E,
                              8'h5A, 8'h76, 8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h75, 8'h3D};

    initial begin
        int seen;
        reset = 1'b0; scan_code = 8'h00; scan_ready = 1'b0; tok_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic sequence with releases
        send(8'h16, 1); send(8'hF0, 1); send(8'h16, 1); send(8'h55, 1);
        send(8'hF0, 1); send(8'h55, 1); send(8'h1E, 1); send(8'hF0, 1);
        send(8'h1E, 1); send(8'h5A, 1); idle(3, 1);
        chk_got("seq_basic", '{1, 16, 2, 32});

        // Typematic repeats
        do_reset();
        send(8'h26, 1); send(8'h26, 1); send(8'h26, 1); send(8'hF0, 1);
        send(8'h26, 1); send(8'h26, 1); idle(3, 1);
        chk_got("typematic", '{3, 3});

        // Fill, overflow, then push+pop while full
        do_reset();
        send(8'h45, 0); send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0);
        chk("full_no_ovf", int'(overflow), 0);
        send(8'h25, 0);
        chk("ovf_set", int'(overflow), 1);
        send(8'h2E, 1);
        idle(6, 1);
        chk_got("fifo_order", '{0, 1, 2, 3, 5});

        // Unknown make, extended enter, extended other
        do_reset();
        send(8'h1C, 1);
        chk("err_1c", int'(err_pulse), 1);
        idle(1, 1);
        chk("err_1c_end", int'(err_pulse), 0);
        send(8'hE0, 1); send(8'h5A, 1); send(8'hE0, 1); send(8'h75, 1);
        idle(3, 1);
        chk_got("ext", '{32});

        // Prefix timeout
        do_reset();
        send(8'hF0, 1);
        seen = -1;
        for (int j = 1; j <= 40; j++) begin
            idle(1, 1);
            if (timeout_pulse && seen < 0) seen = j;
        end
        chk("tmo_cycle", seen, TMO);
        send(8'h45, 1); idle(3, 1);
        chk_got("after_tmo", '{0});

        // Reset in the middle of a break sequence
        do_reset();
        send(8'hF0, 1);
        do_reset();
        send(8'h16, 1); idle(3, 1);
        chk_got("after_rst", '{1});
        chk("after_rst_ovf", int'(overflow), 0);
        chk("after_rst_err", int'(err_pulse), 0);
        chk("after_rst_tmo", int'(timeout_pulse), 0);

        // Random byte streams
        do_reset();
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 30) == 0) begin
                idle($urandom_range(10, 25), 1'($urandom_range(0, 1)));
            end else begin
                logic [7:0] b;
                b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
                cyc(b, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
        end
        idle(8, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
